interleave: RTL and testbench
=============================

// Module: interleave
// PURPOSE
// - TX-side OFDM bit interleaver: inverse of the RX deinterleaver. Takes convolutionally coded, punctured bits
//   one per handshake and emits one subcarrier word (N_BPSC bits) per handshake in 802.11a/n interleaved order.
// - Sits between the puncturer and the constellation mapper. Legacy (48 SC) and HT-20 (52 SC) rates.
// PARAMETERS
// - MAX_CBPS  312  bits per bank (HT MCS7: 52*6); sets bank depth and address width (9)
// PORTS
// - clock      in   1  single clock domain
// - reset_n    in   1  asynchronous, active-low reset
// - enable     in   1  0: all state frozen, in_ready=0, out_valid held
// - clear      in   1  sync abort: both banks emptied, counters zeroed, rate_err cleared
// - rate       in   8  rate[7]=ht, rate[3:0] code; sampled on first bit of each symbol
// - in_bit     in   1  coded bit, in_valid/in_ready handshake
// - in_valid   in   1
// - in_ready   out  1
// - out_bits   out  6  out_bits[b] = interleaved bit N_BPSC*sc+b; bits >= N_BPSC are 0
// - out_valid  out  1  out_valid/out_ready handshake; out_bits stable while valid&!ready
// - out_ready  in   1
// - out_last   out  1  high with final subcarrier word of a symbol
// - out_rate   out  8  rate latched for the symbol being read
// - rate_err   out  1  sticky: unsupported rate sampled
// BEHAVIOUR
// - Reset/clear: in_ready=0 under reset, 1 on first enabled cycle after; out_valid=0, out_bits=0, out_last=0,
//   out_rate=0, rate_err=0; both banks empty; write bank=0.
// - Rate table: legacy 1011,1111 BPSK; 1010,1110 QPSK; 1001,1101 16QAM; 1000,1100 64QAM.
//   HT 0000 BPSK; 0001,0010 QPSK; 0011,0100 16QAM; 0101,0110,0111 64QAM. N_BPSC=1/2/4/6.
//   N_COL=16 legacy / 13 HT; N_ROW=N_COL==16 ? 3*N_BPSC : 4*N_BPSC; N_CBPS=N_COL*N_ROW; s=max(N_BPSC/2,1).
// - Write: input bit k (0..N_CBPS-1) stored at bank address j(k), col=k mod N_COL, row=k/N_COL:
//   i=N_ROW*col+row; j=i-(i mod s)+((i-col) mod s). Compute incrementally (col,row,i, i mod s tracked by
//   counters), no multipliers/dividers; result must equal the 802.11 two-permutation formula exactly.
// - Ping-pong: 2 banks x MAX_CBPS bits + per-bank rate tag + full flag. Writer fills write bank; on
//   acceptance of bit N_CBPS-1 that bank is marked full, writer toggles bank, k resets.
// - in_ready = enable & !clear & !rate_err & (write bank not full). Both banks full -> in_ready=0.
// - Unsupported rate on a symbol's first bit: bit not accepted, rate_err=1, in_ready=0 until clear.
// - Read: when read bank full, words sc=0..N_SC-1 presented; out_bits registered from bits
//   [N_BPSC*sc +: N_BPSC]. Latency: out_valid high on the cycle after the edge accepting the last input bit.
//   Back-to-back words with out_ready=1; after handshake of out_last word bank freed, read bank toggles;
//   next full bank's first word follows with no bubble.
// - Simultaneous free of read bank and fill of write bank in one cycle: both take effect; no bit lost.
// - rate changes mid-symbol ignored; ht toggle only takes effect at next symbol start.
// - Reset or clear mid-symbol: partial symbol discarded, no out_valid for it.
// STRUCTURE
// - Shared package (openofdm_tx_pkg): rate-code localparams, mod-type enum, N_BPSC/N_COL/N_ROW decode
//   function, MAX_CBPS. Same decode used by mapper and puncturer.
// - One sub-module: interleave_addr_gen (k -> j counter pipeline, 0-cycle combinational output of registered
//   counters, inputs: step, restart, n_col, n_row, s). Bank storage as flop array in the top.
// TESTING
// - Legacy 6M (rate=0x0B), 48 bits, only k=1 set -> sc 3 out_bits=000001, all others 0, out_last at sc 47.
// - Legacy 24M (0x09), only k=17 set -> j=12: sc 3 out_bits=000001; 48 words; out_rate=0x09.
// - HT MCS7 (0x87), only k=14 set -> j=24: sc 4 out_bits=000001; 52 words total; full random frame vs model.
// - Three symbols streamed, out_ready=0 for 400 cycles -> in_ready drops after 2 symbols, no loss/reorder,
//   outputs match golden model, no bubble between symbols when out_ready=1.
// - rate=0x05 on first bit -> rate_err=1, in_ready=0, no output; clear pulse -> rate_err=0, in_ready=1.
// - reset_n low mid-symbol (k=100, HT MCS7) -> out_valid=0 immediately; next full symbol output correct.

Source files
------------

// File: rtl/openofdm_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module  : openofdm_tx_pkg
// Brief   : Rate-code decode shared by the TX puncturer, interleaver and mapper.
// Revision: 1.0
// ============================================================================
package openofdm_tx_pkg;

    localparam int MAX_CBPS = 312;
    localparam int ADDR_W   = 9;

    localparam logic [3:0] RATE_L_6M  = 4'b1011;
    localparam logic [3:0] RATE_L_9M  = 4'b1111;
    localparam logic [3:0] RATE_L_12M = 4'b1010;
    localparam logic [3:0] RATE_L_18M = 4'b1110;
    localparam logic [3:0] RATE_L_24M = 4'b1001;
    localparam logic [3:0] RATE_L_36M = 4'b1101;
    localparam logic [3:0] RATE_L_48M = 4'b1000;
    localparam logic [3:0] RATE_L_54M = 4'b1100;

    typedef enum logic [1:0] {
        MOD_BPSK  = 2'd0,
        MOD_QPSK  = 2'd1,
        MOD_16QAM = 2'd2,
        MOD_64QAM = 2'd3
    } mod_t;

    typedef struct packed {
        logic        supported;
        logic        ht;
        mod_t        modu;
        logic [2:0]  n_bpsc;
        logic [4:0]  n_col;
        logic [4:0]  n_row;
        logic [1:0]  s;
        logic [8:0]  n_cbps;
        logic [5:0]  n_sc;
    } rate_cfg_t;

    function automatic rate_cfg_t decode_rate(input logic [7:0] rate);
        rate_cfg_t cfg;
        cfg           = '0;
        cfg.ht        = rate[7];
        cfg.supported = 1'b1;
        cfg.modu      = MOD_BPSK;
        if (rate[7]) begin
            case (rate[3:0])
                4'd0:             cfg.modu = MOD_BPSK;
                4'd1, 4'd2:       cfg.modu = MOD_QPSK;
                4'd3, 4'd4:       cfg.modu = MOD_16QAM;
                4'd5, 4'd6, 4'd7: cfg.modu = MOD_64QAM;
                default:          cfg.supported = 1'b0;
            endcase
        end else begin
            case (rate[3:0])
                RATE_L_6M,  RATE_L_9M:  cfg.modu = MOD_BPSK;
                RATE_L_12M, RATE_L_18M: cfg.modu = MOD_QPSK;
                RATE_L_24M, RATE_L_36M: cfg.modu = MOD_16QAM;
                RATE_L_48M, RATE_L_54M: cfg.modu = MOD_64QAM;
                default:                cfg.supported = 1'b0;
            endcase
        end
        case (cfg.modu)
            MOD_BPSK: begin
                cfg.n_bpsc = 3'd1; cfg.s = 2'd1;
                cfg.n_row  = cfg.ht ? 5'd4  : 5'd3;
                cfg.n_cbps = cfg.ht ? 9'd52 : 9'd48;
            end
            MOD_QPSK: begin
                cfg.n_bpsc = 3'd2; cfg.s = 2'd1;
                cfg.n_row  = cfg.ht ? 5'd8   : 5'd6;
                cfg.n_cbps = cfg.ht ? 9'd104 : 9'd96;
            end
            MOD_16QAM: begin
                cfg.n_bpsc = 3'd4; cfg.s = 2'd2;
                cfg.n_row  = cfg.ht ? 5'd16  : 5'd12;
                cfg.n_cbps = cfg.ht ? 9'd208 : 9'd192;
            end
            default: begin
                cfg.n_bpsc = 3'd6; cfg.s = 2'd3;
                cfg.n_row  = cfg.ht ? 5'd24  : 5'd18;
                cfg.n_cbps = cfg.ht ? 9'd312 : 9'd288;
            end
        endcase
        cfg.n_col = cfg.ht ? 5'd13 : 5'd16;
        cfg.n_sc  = cfg.ht ? 6'd52 : 6'd48;
        return cfg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/interleave_addr_gen.sv
`default_nettype none
// ============================================================================
// Module  : interleave_addr_gen
// Brief   : Incremental k -> j interleaver address generator (no multipliers).
// Revision: 1.0
// ============================================================================
module interleave_addr_gen
    import openofdm_tx_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              step,
    input  logic              restart,
    input  logic [4:0]        n_col,
    input  logic [4:0]        n_row,
    input  logic [1:0]        s,
    output logic [ADDR_W-1:0] addr
);

    logic [4:0]        col_q, col_d;
    logic [4:0]        row_q, row_d;
    logic [ADDR_W-1:0] i_q, i_d;
    logic [1:0]        col_mod_q, col_mod_d;
    logic [1:0]        row_mod_q, row_mod_d;
    logic [1:0]        diff;

    // N_ROW is always a multiple of s, so i mod s == row mod s.
    always_comb begin
        col_d     = col_q;
        row_d     = row_q;
        i_d       = i_q;
        col_mod_d = col_mod_q;
        row_mod_d = row_mod_q;
        if (restart) begin
            col_d     = '0;
            row_d     = '0;
            i_d       = '0;
            col_mod_d = '0;
            row_mod_d = '0;
        end else if (step) begin
            if (col_q == n_col - 5'd1) begin
                col_d     = '0;
                row_d     = row_q + 5'd1;
                i_d       = {4'd0, row_q + 5'd1};
                col_mod_d = '0;
                row_mod_d = (row_mod_q == s - 2'd1) ? 2'd0 : row_mod_q + 2'd1;
            end else begin
                col_d     = col_q + 5'd1;
                i_d       = i_q + {4'd0, n_row};
                col_mod_d = (col_mod_q == s - 2'd1) ? 2'd0 : col_mod_q + 2'd1;
            end
        end
    end

    always_comb begin
        if (row_mod_q >= col_mod_q) diff = row_mod_q - col_mod_q;
        else                        diff = row_mod_q + s - col_mod_q;
        addr = i_q - {7'd0, row_mod_q} + {7'd0, diff};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            col_q     <= '0;
            row_q     <= '0;
            i_q       <= '0;
            col_mod_q <= '0;
            row_mod_q <= '0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            i_q       <= i_d;
            col_mod_q <= col_mod_d;
            row_mod_q <= row_mod_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/interleave.sv
`default_nettype none
// ============================================================================
// Module  : interleave
// Brief   : 802.11a/n TX bit interleaver, ping-pong banks, one SC word per beat.
// Revision: 1.0
// ============================================================================
module interleave
    import openofdm_tx_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       clear,
    input  logic [7:0] rate,
    input  logic       in_bit,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [5:0] out_bits,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic [7:0] out_rate,
    output logic       rate_err
);

    logic [1:0][MAX_CBPS-1:0] bank_q, bank_d;
    logic [1:0][7:0]          tag_q, tag_d;
    logic [1:0]               full_q, full_d;
    logic                     wr_bank_q, wr_bank_d;
    logic                     rd_bank_q, rd_bank_d;
    logic [8:0]               k_q, k_d;
    logic                     rate_err_q, rate_err_d;
    logic                     out_valid_q, out_valid_d;
    logic [5:0]               out_bits_q, out_bits_d;
    logic                     out_last_q, out_last_d;
    logic [7:0]               out_rate_q, out_rate_d;
    logic [5:0]               rd_sc_q, rd_sc_d;
    logic [8:0]               rd_ptr_q, rd_ptr_d;

    logic        first_bit, last_bit, accept, reject, rd_other;
    logic [7:0]  cur_rate;
    logic [8:0]  wr_addr;
    rate_cfg_t   cfg_wr, cfg_cur, cfg_ld;
    logic        unused_cfg;

    // The rate is only looked at on a symbol's first bit; afterwards the bank tag governs.
    assign first_bit = (k_q == 9'd0);
    assign cur_rate  = first_bit ? rate : tag_q[wr_bank_q];
    assign cfg_wr    = decode_rate(cur_rate);
    assign cfg_cur   = decode_rate(tag_q[rd_bank_q]);
    assign in_ready  = reset_n & enable & ~clear & ~rate_err_q & ~full_q[wr_bank_q];
    assign reject    = in_valid & in_ready & first_bit & ~cfg_wr.supported;
    assign accept    = in_valid & in_ready & ~reject;
    assign last_bit  = (k_q == cfg_wr.n_cbps - 9'd1);
    assign rd_other  = ~rd_bank_q;

    assign unused_cfg = ^{cfg_wr, cfg_cur, cfg_ld};

    interleave_addr_gen u_addr_gen (
        .clock   (clock),
        .reset_n (reset_n),
        .step    (accept & ~last_bit),
        .restart (clear | (accept & last_bit)),
        .n_col   (cfg_wr.n_col),
        .n_row   (cfg_wr.n_row),
        .s       (cfg_wr.s),
        .addr    (wr_addr)
    );

    always_comb begin : p_next
        logic       ld_ok;
        logic       ld_bank;
        logic       free_bank;
        logic [5:0] ld_sc;
        logic [8:0] ld_ptr;
        logic [8:0] bit_idx;

        bank_d      = bank_q;
        tag_d       = tag_q;
        full_d      = full_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        k_d         = k_q;
        rate_err_d  = rate_err_q;
        out_valid_d = out_valid_q;
        out_bits_d  = out_bits_q;
        out_last_d  = out_last_q;
        out_rate_d  = out_rate_q;
        rd_sc_d     = rd_sc_q;
        rd_ptr_d    = rd_ptr_q;
        ld_ok       = 1'b0;
        ld_bank     = rd_bank_q;
        free_bank   = 1'b0;
        ld_sc       = '0;
        ld_ptr      = '0;
        bit_idx     = '0;

        if (accept) begin
            bank_d[wr_bank_q][wr_addr] = in_bit;
            if (first_bit) tag_d[wr_bank_q] = rate;
            if (last_bit) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
                k_d               = '0;
            end else begin
                k_d = k_q + 9'd1;
            end
        end
        if (reject) rate_err_d = 1'b1;

        // Reads see full_d/bank_d so a just-completed bank is presented without delay.
        if (enable) begin
            if (!out_valid_q) begin
                ld_ok = full_d[rd_bank_q];
            end else if (out_ready) begin
                if (!out_last_q) begin
                    ld_ok  = 1'b1;
                    ld_sc  = rd_sc_q + 6'd1;
                    ld_ptr = rd_ptr_q + {6'd0, cfg_cur.n_bpsc};
                end else begin
                    free_bank = 1'b1;
                    ld_bank   = rd_other;
                    ld_ok     = full_d[rd_other];
                end
            end
        end

        cfg_ld = decode_rate(tag_d[ld_bank]);

        if (free_bank) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = rd_other;
            out_valid_d       = 1'b0;
            out_bits_d        = '0;
            out_last_d        = 1'b0;
        end

        if (ld_ok) begin
            out_valid_d = 1'b1;
            out_bits_d  = '0;
            for (int b = 0; b < 6; b++) begin
                bit_idx = ld_ptr + 9'(b);
                if ((3'(b) < cfg_ld.n_bpsc) && (bit_idx < 9'(MAX_CBPS)))
                    out_bits_d[b] = bank_d[ld_bank][bit_idx];
            end
            out_last_d = (ld_sc == cfg_ld.n_sc - 6'd1);
            out_rate_d = tag_d[ld_bank];
            rd_sc_d    = ld_sc;
            rd_ptr_d   = ld_ptr;
            rd_bank_d  = ld_bank;
        end

        if (clear) begin
            full_d      = '0;
            wr_bank_d   = 1'b0;
            rd_bank_d   = 1'b0;
            k_d         = '0;
            rate_err_d  = 1'b0;
            out_valid_d = 1'b0;
            out_bits_d  = '0;
            out_last_d  = 1'b0;
            out_rate_d  = '0;
            rd_sc_d     = '0;
            rd_ptr_d    = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bank_q      <= '0;
            tag_q       <= '0;
            full_q      <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            k_q         <= '0;
            rate_err_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_bits_q  <= '0;
            out_last_q  <= 1'b0;
            out_rate_q  <= '0;
            rd_sc_q     <= '0;
            rd_ptr_q    <= '0;
        end else begin
            bank_q      <= bank_d;
            tag_q       <= tag_d;
            full_q      <= full_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            k_q         <= k_d;
            rate_err_q  <= rate_err_d;
            out_valid_q <= out_valid_d;
            out_bits_q  <= out_bits_d;
            out_last_q  <= out_last_d;
            out_rate_q  <= out_rate_d;
            rd_sc_q     <= rd_sc_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_bits  = out_bits_q;
    assign out_last  = out_last_q;
    assign out_rate  = out_rate_q;
    assign rate_err  = rate_err_q;

endmodule
`default_nettype wire

// File: tb/tb_interleave.sv
`default_nettype none
// ============================================================================
// Module  : tb_interleave
// Brief   : Directed bench for interleave with a reference-formula scoreboard.
// Revision: 1.0
// ============================================================================
module tb_interleave;

    logic       clock = 1'b0;
    logic       reset_n, enable, clear, in_bit, in_valid, out_ready;
    logic [7:0] rate;
    logic       in_ready, out_valid, out_last, rate_err;
    logic [5:0] out_bits;
    logic [7:0] out_rate;

    always #5 clock = ~clock;

    interleave dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .enable    (enable),
        .clear     (clear),
        .rate      (rate),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_bits  (out_bits),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_rate  (out_rate),
        .rate_err  (rate_err)
    );

    typedef struct packed {
        logic [5:0] bits;
        logic       last;
        logic [7:0] rate;
    } exp_t;

    exp_t sb[$];
    int   pop_cyc[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    function automatic int nbpsc_of(input logic [7:0] r);
        if (r[7]) begin
            case (r[3:0])
                4'd0:             return 1;
                4'd1, 4'd2:       return 2;
                4'd3, 4'd4:       return 4;
                4'd5, 4'd6, 4'd7: return 6;
                default:          return 0;
            endcase
        end
        case (r[3:0])
            4'd11, 4'd15: return 1;
            4'd10, 4'd14: return 2;
            4'd9,  4'd13: return 4;
            4'd8,  4'd12: return 6;
            default:      return 0;
        endcase
    endfunction

    function automatic int ncol_of(input logic [7:0] r);
        return r[7] ? 13 : 16;
    endfunction

    function automatic int nrow_of(input logic [7:0] r);
        return (ncol_of(r) == 16) ? 3 * nbpsc_of(r) : 4 * nbpsc_of(r);
    endfunction

    function automatic int ncbps_of(input logic [7:0] r);
        return ncol_of(r) * nrow_of(r);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: the two 802.11 permutations evaluated directly.
    task automatic push_expected(input logic [7:0] r, input logic [311:0] v);
        int nb, nc, nr, ncbps, s, i, j, nsc;
        logic [311:0] ilv;
        exp_t e;
        nb    = nbpsc_of(r);
        nc    = ncol_of(r);
        nr    = nrow_of(r);
        ncbps = nc * nr;
        s     = (nb / 2 > 1) ? nb / 2 : 1;
        nsc   = ncbps / nb;
        ilv   = '0;
        for (int k = 0; k < ncbps; k++) begin
            i = (ncbps / nc) * (k % nc) + k / nc;
            j = s * (i / s) + (i + ncbps - (nc * i) / ncbps) % s;
            ilv[j] = v[k];
        end
        for (int sc = 0; sc < nsc; sc++) begin
            e.bits = '0;
            for (int b = 0; b < nb; b++) e.bits[b] = ilv[nb * sc + b];
            e.last = (sc == nsc - 1);
            e.rate = r;
            sb.push_back(e);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        cyc++;
        if (reset_n && enable && !clear && out_valid && out_ready) begin
            pop_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_word observed=%b expected=none", out_bits);
            end else begin
                e = sb.pop_front();
                checks++;
                assert (out_bits === e.bits) else begin
                    errors++;
                    $error("FAIL out_bits observed=%b expected=%b", out_bits, e.bits);
                end
                checks++;
                assert (out_last === e.last) else begin
                    errors++;
                    $error("FAIL out_last observed=%b expected=%b", out_last, e.last);
                end
                checks++;
                assert (out_rate === e.rate) else begin
                    errors++;
                    $error("FAIL out_rate observed=%h expected=%h", out_rate, e.rate);
                end
            end
        end
    end

    task automatic send_bits(input logic [7:0] r, input logic [311:0] v, input int nbits,
                             input bit push, input bit scramble);
        int w;
        if (push) push_expected(r, v);
        rate = r;
        for (int k = 0; k < nbits; k++) begin
            in_bit   = v[k];
            in_valid = 1'b1;
            w        = 0;
            while (!in_ready && w < 2000) begin
                @(posedge clock); #1;
                w++;
            end
            if (w >= 2000) begin
                checks++;
                errors++;
                $error("FAIL in_ready_timeout observed=0 expected=1 k=%0d", k);
                in_valid = 1'b0;
                return;
            end
            @(posedge clock); #1;
            if (scramble && k == 0) rate = 8'h05;
        end
        in_valid = 1'b0;
    endtask

    task automatic send_symbol(input logic [7:0] r, input logic [311:0] v, input bit scramble);
        send_bits(r, v, ncbps_of(r), 1'b1, scramble);
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 3000) begin
            @(posedge clock); #1;
            w++;
        end
        check("drain_remaining", sb.size(), 0);
        repeat (2) @(posedge clock);
        #1;
        check("idle_out_valid", out_valid, 0);
    endtask

    function automatic logic [311:0] rand_vec();
        logic [311:0] v;
        for (int k = 0; k < 312; k++) v[k] = 1'($urandom);
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [311:0] v;
        reset_n   = 1'b0;
        enable    = 1'b1;
        clear     = 1'b0;
        rate      = 8'h00;
        in_bit    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("rst_in_ready",  in_ready,  0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_bits",  out_bits,  0);
        check("rst_out_last",  out_last,  0);
        check("rst_out_rate",  out_rate,  0);
        check("rst_rate_err",  rate_err,  0);
        reset_n = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        @(posedge clock); #1;

        v = '0; v[1] = 1'b1;
        send_symbol(8'h0B, v, 1'b0);
        check("lat_out_valid", out_valid, 1);
        wait_drain();

        v = '0; v[17] = 1'b1;
        send_symbol(8'h09, v, 1'b1);
        wait_drain();

        v = '0; v[14] = 1'b1;
        send_symbol(8'h87, v, 1'b0);
        wait_drain();

        send_symbol(8'h87, rand_vec(), 1'b0);
        send_symbol(8'h0E, rand_vec(), 1'b0);
        send_symbol(8'h83, rand_vec(), 1'b0);
        send_symbol(8'h0C, rand_vec(), 1'b0);
        wait_drain();

        enable = 1'b0;
        #1;
        check("disabled_in_ready", in_ready, 0);
        @(posedge clock); #1;
        enable = 1'b1;
        #1;
        check("enabled_in_ready", in_ready, 1);

        out_ready = 1'b0;
        send_symbol(8'h87, rand_vec(), 1'b0);
        send_symbol(8'h0B, rand_vec(), 1'b0);
        check("both_full_in_ready", in_ready, 0);
        check("both_full_out_valid", out_valid, 1);
        repeat (400) @(posedge clock);
        #1;
        check("stall_in_ready", in_ready, 0);
        check("stall_sb_size", sb.size(), 100);
        pop_cyc.delete();
        out_ready = 1'b1;
        send_symbol(8'h09, rand_vec(), 1'b0);
        wait_drain();
        check("stream_pops", pop_cyc.size(), 148);
        if (pop_cyc.size() >= 100)
            check("no_bubble_span", pop_cyc[99] - pop_cyc[0], 99);

        rate     = 8'h05;
        in_bit   = 1'b1;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        check("bad_rate_err", rate_err, 1);
        check("bad_rate_in_ready", in_ready, 0);
        repeat (10) @(posedge clock);
        #1;
        check("bad_rate_no_output", out_valid, 0);
        clear = 1'b1;
        @(posedge clock); #1;
        clear = 1'b0;
        #1;
        check("clear_rate_err", rate_err, 0);
        check("clear_in_ready", in_ready, 1);
        send_symbol(8'h0F, rand_vec(), 1'b0);
        wait_drain();

        send_bits(8'h87, rand_vec(), 100, 1'b0, 1'b0);
        reset_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        send_symbol(8'h87, rand_vec(), 1'b0);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
